data_sram_responder: RTL

// Responder (memory side) of the single-port SRAM-like bus that the CPU core drives
// on data_sram_* / inst_sram_* (en, wen[3:0], addr, wdata -> rdata).

---
 rtl/data_sram_responder.sv | 99 +++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// Word-addressed SRAM responder with byte-lane writes and registered read data.
// Optional wait states (signalled on stallreq) and an out-of-range error pulse.
//
// state   | meaning
// ST_IDLE | no access pending; a request completes now (no wait states) or starts stalling
// ST_WAIT | request held by the initiator; cnt = stall cycles still to go
module data_sram_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        stallreq,
  output logic        addr_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] RELOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  access;
  logic                  do_write;
  logic [1:0]            unused_addr_lsb;

  assign idx             = sram_addr[ADDR_WIDTH+1:2];
  assign in_range        = (sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign unused_addr_lsb = sram_addr[1:0];

  // Access happens on the last cycle of a held request; earlier cycles only stall.
  always_comb begin
    access   = 1'b0;
    stallreq = 1'b0;
    if (!rst && sram_en) begin
      if (!HAS_WAIT)
        access = 1'b1;
      else if (state == ST_IDLE || cnt != 4'd0)
        stallreq = 1'b1;
      else
        access = 1'b1;
    end
  end

  assign do_write = access && in_range && (sram_wen != 4'b0000);

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[idx][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      sram_rdata <= 32'd0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      if (access) begin
        if (!in_range) begin
          sram_rdata <= 32'd0;
          addr_err   <= 1'b1;
        end else if (sram_wen == 4'b0000) begin
          sram_rdata <= mem[idx];
        end
      end
      case (state)
        ST_IDLE: begin
          if (sram_en && HAS_WAIT) begin
            cnt   <= RELOAD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!sram_en || cnt == 4'd0)
            state <= ST_IDLE;
          else
            cnt <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
